uart_sfifo_fwft: RTL and testbench
==================================

# uart_sfifo_fwft

Parametrised synchronous FIFO for the UART TX/RX datapaths, with first-word-fall-through (show-ahead) output and full-rate streaming. Words can be popped on back-to-back cycles with no bubble. Adds programmable almost-full/almost-empty flags, a synchronous flush and a sticky overflow flag. It sits between the UART shift engines and the bus-side register interface and replaces the bubble-per-read FIFO in new designs.

## Interface
- DATA_BIT, 8, word width in bits
- ADDR_BIT, 4, RAM address width; capacity DEPTH = 2^ADDR_BIT words
- AFULL_LVL, 2^ADDR_BIT-2, almost_full asserts when count_out >= AFULL_LVL (legal range 1..DEPTH)
- AEMPTY_LVL, 2, almost_empty asserts when count_out <= AEMPTY_LVL (legal range 0..DEPTH-1)

Ports:
- clk  in  1  clock, all state updates on the rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  synchronous clear of contents; does not reset parameters
- w_data  in  DATA_BIT  write word
- w_valid  in  1  write request
- w_ready  out  1  FIFO can accept; equals ~full
- r_data  out  DATA_BIT  head word; valid when r_valid=1
- r_valid  out  1  head word present
- r_ready  in  1  consumer accepts head
- count_out  out  ADDR_BIT+1  words accepted and not yet popped, 0..DEPTH
- empty  out  1  count_out == 0
- full  out  1  count_out == DEPTH
- almost_full  out  1  count_out >= AFULL_LVL
- almost_empty  out  1  count_out <= AEMPTY_LVL
- overflow  out  1  sticky: write attempted while full

## Operation
- Push = w_valid & w_ready; pop = r_valid & r_ready. Both may occur in the same cycle.
- Storage is a dual-port RAM with a registered read (one cycle), plus a prefetch/output stage.
- The output stage is loaded whenever it is empty or being popped and an unread word exists, so r_valid stays high across consecutive pops while count_out >= 2.
- count_out update: +1 on push only, -1 on pop only, unchanged on both or neither. Width ADDR_BIT+1, never wraps.
- count_out includes words still in flight to the output stage, so r_valid=0 with count_out>0 is legal for at most 2 cycles.
- Write and read pointers are ADDR_BIT wide and wrap modulo DEPTH.
- Ordering is strict FIFO across wrap-around.
- When r_valid=1 and r_ready=0, r_data and r_valid hold stable until the pop.
- Full: w_ready=0, and no write occurs even if a pop happens the same cycle. w_valid while full sets overflow; the data is dropped.
- Flush has priority over push and pop in its cycle.
  - Pointers, count_out and the output stage clear; overflow clears; r_valid=0 the next cycle.
  - A word offered in the flush cycle is discarded.
- Reset mid-operation behaves as flush, plus r_data returns to 0.
- Flags empty, full, almost_full and almost_empty decode combinationally from the registered count_out.

## Timing
- Reset values: count_out=0, empty=1, full=0, w_ready=1, r_valid=0, r_data=0, almost_empty=1, almost_full=0 (AFULL_LVL>=1), overflow=0.
- Latency: a word pushed at edge N into an empty FIFO gives r_valid=1 after edge N+2. No combinational path from w_* to r_*.
- Streaming throughput: one push and one pop per cycle indefinitely once r_valid is established.
- Pop at edge N with count_out>=3 before the edge: r_valid stays 1 after N and r_data shows the next word.
- A flag change appears in the same cycle as the count_out change, one edge after the push or pop.
- overflow sets after the edge on which w_valid & full is sampled. It holds until flush or reset.

## Test plan
- Reset, then push 0x11 at edge 1 with r_ready=0 -> r_valid=1 and r_data=0x11 after edge 3; count_out=1; empty=0; almost_empty=1.
- ADDR_BIT=4: push 16 words 0x00..0x0F, then push 0xAA -> full=1, w_ready=0 from edge 16, overflow=1 after the 17th attempt; 0xAA never read back.
- From full, r_ready=1 continuously -> 16 pops on consecutive cycles, data 0x00..0x0F in order; empty=1 after the last pop; overflow still 1.
- Simultaneous push/pop at count_out=5 for 40 cycles (pointers wrap twice) -> count_out stays 5; output sequence matches input order exactly.
- Hold r_ready=0 for 10 cycles with r_valid=1 -> r_data is unchanged throughout; pop on cycle 11 advances to the next word.
- Fill with 7 words, assert flush together with w_valid (0x55) -> next cycle count_out=0, empty=1, r_valid=0, overflow=0; a later push of 0x66 is the first word read.

Source files
------------

// File: rtl/uart_sfifo_fwft.sv
// Show-ahead synchronous FIFO for the UART datapaths: RAM with registered read,
// a one-word prefetch stage and an output register so pops can run every cycle.
module uart_sfifo_fwft #(
  parameter int DATA_BIT   = 8,
  parameter int ADDR_BIT   = 4,
  parameter int AFULL_LVL  = (2 ** ADDR_BIT) - 2,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic [DATA_BIT-1:0] w_data,
  input  logic                w_valid,
  output logic                w_ready,
  output logic [DATA_BIT-1:0] r_data,
  output logic                r_valid,
  input  logic                r_ready,
  output logic [ADDR_BIT:0]   count_out,
  output logic                empty,
  output logic                full,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                overflow
);

  localparam int                DEPTH    = 1 << ADDR_BIT;
  localparam logic [ADDR_BIT:0] DEPTH_C  = (ADDR_BIT + 1)'(DEPTH);
  localparam logic [ADDR_BIT:0] AFULL_C  = (ADDR_BIT + 1)'(AFULL_LVL);
  localparam logic [ADDR_BIT:0] AEMPTY_C = (ADDR_BIT + 1)'(AEMPTY_LVL);

  logic [DATA_BIT-1:0] mem [DEPTH];
  logic [ADDR_BIT-1:0] wr_ptr;
  logic [ADDR_BIT-1:0] rd_ptr;
  logic [DATA_BIT-1:0] mid_data;
  logic                mid_valid;
  logic [ADDR_BIT:0]   count_q;
  logic [ADDR_BIT:0]   in_flight;
  logic [ADDR_BIT:0]   ram_words;
  logic                push;
  logic                pop;
  logic                out_load;
  logic                rd_issue;

  assign count_out    = count_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);
  assign w_ready      = ~full;

  assign push = w_valid & w_ready;
  assign pop  = r_valid & r_ready;

  // count_q covers RAM words plus those already in the prefetch/output stages,
  // so the difference is what is still unread in the RAM.
  assign in_flight = {{ADDR_BIT{1'b0}}, r_valid} + {{ADDR_BIT{1'b0}}, mid_valid};
  assign ram_words = count_q - in_flight;
  assign out_load  = mid_valid & (~r_valid | r_ready);
  assign rd_issue  = (ram_words != '0) & (~mid_valid | out_load);

  always_ff @(posedge clk) begin
    if (push && !flush && !reset) begin
      mem[wr_ptr] <= w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      mid_data  <= '0;
      mid_valid <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      overflow  <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      mid_valid <= 1'b0;
      r_valid   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_issue) begin
        mid_data <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      mid_valid <= rd_issue | (mid_valid & ~out_load);
      if (out_load) begin
        r_data <= mid_data;
      end
      r_valid <= out_load | (r_valid & ~r_ready);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (w_valid && full) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_sfifo_fwft.sv
// Directed bench for uart_sfifo_fwft: latency, fill/overflow, drain, streaming,
// hold stability, flush and reset.
module tb_uart_sfifo_fwft;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic [7:0] w_data = '0;
  logic       w_valid = 1'b0;
  logic       w_ready;
  logic [7:0] r_data;
  logic       r_valid;
  logic       r_ready = 1'b0;
  logic [4:0] count_out;
  logic       empty, full, almost_full, almost_empty, overflow;

  int compared = 0;
  int mismatched = 0;

  uart_sfifo_fwft dut (
    .clk(clk), .reset(reset), .flush(flush),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .r_data(r_data), .r_valid(r_valid), .r_ready(r_ready),
    .count_out(count_out), .empty(empty), .full(full),
    .almost_full(almost_full), .almost_empty(almost_empty), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    compared++;
    if ({count_out, empty, full, w_ready, r_valid, r_data, almost_empty, almost_full, overflow}
        !== {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL reset_state: count=%0d empty=%b full=%b w_ready=%b r_valid=%b r_data=%h ae=%b af=%b ovf=%b, want 0 1 0 1 0 00 1 0 0",
               count_out, empty, full, w_ready, r_valid, r_data, almost_empty, almost_full, overflow);
    end
    reset = 1'b0;
  endtask

  task automatic test_first_word();
    w_valid = 1'b1; w_data = 8'h11;
    step();
    w_valid = 1'b0;
    compared++;
    if (count_out !== 5'd1 || r_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL first_edge1: count=%0d r_valid=%b, want 1 0", count_out, r_valid);
    end
    step();
    compared++;
    if (r_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL first_edge2: r_valid=%b, want 0", r_valid);
    end
    step();
    compared++;
    if (r_valid !== 1'b1 || r_data !== 8'h11 || count_out !== 5'd1 || empty !== 1'b0 || almost_empty !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL first_edge3: r_valid=%b r_data=%h count=%0d empty=%b ae=%b, want 1 11 1 0 1",
               r_valid, r_data, count_out, empty, almost_empty);
    end
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;
    compared++;
    if (empty !== 1'b1 || r_valid !== 1'b0 || count_out !== 5'd0) begin
      mismatched++;
      $display("[TB] FAIL first_pop: empty=%b r_valid=%b count=%0d, want 1 0 0", empty, r_valid, count_out);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 16; i++) begin
      w_valid = 1'b1; w_data = 8'(i);
      step();
      compared++;
      if (count_out !== 5'(i + 1) || full !== (i == 15) || almost_full !== (i + 1 >= 14) || w_ready !== (i != 15)) begin
        mismatched++;
        $display("[TB] FAIL fill_%0d: count=%0d full=%b af=%b w_ready=%b", i, count_out, full, almost_full, w_ready);
      end
    end
    w_data = 8'hAA;
    step();
    w_valid = 1'b0;
    compared++;
    if (overflow !== 1'b1 || count_out !== 5'd16 || w_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL overflow_set: ovf=%b count=%0d w_ready=%b, want 1 16 0", overflow, count_out, w_ready);
    end
  endtask

  task automatic test_drain();
    r_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      compared++;
      if (r_valid !== 1'b1 || r_data !== 8'(i)) begin
        mismatched++;
        $display("[TB] FAIL drain_%0d: r_valid=%b r_data=%h, want 1 %h", i, r_valid, r_data, 8'(i));
      end
      step();
    end
    r_ready = 1'b0;
    compared++;
    if (empty !== 1'b1 || r_valid !== 1'b0 || overflow !== 1'b1 || w_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL drain_end: empty=%b r_valid=%b ovf=%b w_ready=%b, want 1 0 1 1", empty, r_valid, overflow, w_ready);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      w_valid = 1'b1; w_data = 8'(8'h20 + i);
      step();
    end
    w_valid = 1'b0;
    step();
    compared++;
    if (count_out !== 5'd5 || r_valid !== 1'b1 || r_data !== 8'h20) begin
      mismatched++;
      $display("[TB] FAIL stream_prefill: count=%0d r_valid=%b r_data=%h, want 5 1 20", count_out, r_valid, r_data);
    end
    for (int i = 0; i < 40; i++) begin
      w_valid = 1'b1; w_data = 8'(8'h25 + i); r_ready = 1'b1;
      compared++;
      if (r_valid !== 1'b1 || r_data !== 8'(8'h20 + i)) begin
        mismatched++;
        $display("[TB] FAIL stream_data_%0d: r_valid=%b r_data=%h, want 1 %h", i, r_valid, r_data, 8'(8'h20 + i));
      end
      step();
      compared++;
      if (count_out !== 5'd5) begin
        mismatched++;
        $display("[TB] FAIL stream_count_%0d: count=%0d, want 5", i, count_out);
      end
    end
    w_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      compared++;
      if (r_valid !== 1'b1 || r_data !== 8'(8'h48 + i)) begin
        mismatched++;
        $display("[TB] FAIL stream_tail_%0d: r_valid=%b r_data=%h, want 1 %h", i, r_valid, r_data, 8'(8'h48 + i));
      end
      step();
    end
    r_ready = 1'b0;
    compared++;
    if (empty !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL stream_empty: empty=%b, want 1", empty);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      w_valid = 1'b1; w_data = 8'(8'h40 + i);
      step();
    end
    w_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      compared++;
      if (r_valid !== 1'b1 || r_data !== 8'h40) begin
        mismatched++;
        $display("[TB] FAIL hold_%0d: r_valid=%b r_data=%h, want 1 40", i, r_valid, r_data);
      end
    end
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;
    compared++;
    if (r_valid !== 1'b1 || r_data !== 8'h41 || count_out !== 5'd2) begin
      mismatched++;
      $display("[TB] FAIL hold_release: r_valid=%b r_data=%h count=%0d, want 1 41 2", r_valid, r_data, count_out);
    end
    r_ready = 1'b1;
    step();
    step();
    r_ready = 1'b0;
    compared++;
    if (empty !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL hold_empty: empty=%b, want 1", empty);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 7; i++) begin
      w_valid = 1'b1; w_data = 8'(8'h50 + i);
      step();
    end
    compared++;
    if (count_out !== 5'd7 || overflow !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL flush_prefill: count=%0d ovf=%b, want 7 1", count_out, overflow);
    end
    flush = 1'b1; w_data = 8'h55;
    step();
    flush = 1'b0; w_valid = 1'b0;
    compared++;
    if (count_out !== 5'd0 || empty !== 1'b1 || r_valid !== 1'b0 || overflow !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL flush_clear: count=%0d empty=%b r_valid=%b ovf=%b, want 0 1 0 0", count_out, empty, r_valid, overflow);
    end
    step();
    step();
    compared++;
    if (r_valid !== 1'b0 || count_out !== 5'd0) begin
      mismatched++;
      $display("[TB] FAIL flush_settle: r_valid=%b count=%0d, want 0 0", r_valid, count_out);
    end
    w_valid = 1'b1; w_data = 8'h66;
    step();
    w_valid = 1'b0;
    step();
    step();
    compared++;
    if (r_valid !== 1'b1 || r_data !== 8'h66 || count_out !== 5'd1) begin
      mismatched++;
      $display("[TB] FAIL flush_next: r_valid=%b r_data=%h count=%0d, want 1 66 1", r_valid, r_data, count_out);
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    step();
    reset = 1'b0;
    compared++;
    if (r_data !== 8'h00 || r_valid !== 1'b0 || count_out !== 5'd0 || empty !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_mid: r_data=%h r_valid=%b count=%0d empty=%b, want 00 0 0 1", r_data, r_valid, count_out, empty);
    end
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_fill_overflow();
    test_drain();
    test_back_to_back();
    test_hold();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
